switch_word_writer: RTL and testbench

//  Write-side front panel for the data memory: assembles a 32-bit write word from
//  8 slide switches one byte lane at a time, then issues a held write request to
//  the memory/register port on a debounced commit button. Dual of the LED byte

---
 rtl/switch_word_writer.sv | 162 ++++++++++++++++
 tb/tb_switch_word_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_word_writer.sv
// Front-panel write path: builds a 32-bit word one byte lane at a time from switches and
// issues a held memory write on a debounced commit press. Optional macro: AUTO_ADDR_INC_EN.

// Button conditioner: 2-flop synchroniser, stability counter and a 1-cycle rise pulse.
module switch_word_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_prev_q, pulse_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: every flop here uses <= so the chain shifts by exactly one stage per edge;
  // blocking assignments would collapse the synchroniser into a single flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      pulse_q      <= level_q & ~level_prev_q;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (sync2_q != level_q) begin
        if (count_q == CNT_W'(DB_CYCLES - 1)) begin
          level_q <= ~level_q;
          count_q <= '0;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end else begin
        count_q <= '0;
      end
    end
  end

  assign pulse_o = pulse_q;
endmodule

module switch_word_writer #(
  parameter int DB_CYCLES = 16,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        SW,
  input  logic [1:0]        Select,
  input  logic [ADDR_W-1:0] Addr_SW,
  input  logic              Load_Btn,
  input  logic              Commit_Btn,
  input  logic              Mem_Ack,
  output logic [31:0]       W_Data,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Req,
  output logic              Busy,
  output logic [7:0]        LED
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e            state_q;
  logic [31:0]       w_data_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] next_addr_d;
  logic              mem_req_q, busy_q;
  logic              load_pulse, commit_pulse;

  switch_word_debounce #(.DB_CYCLES(DB_CYCLES)) u_load_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (Load_Btn),
    .pulse_o(load_pulse)
  );

  switch_word_debounce #(.DB_CYCLES(DB_CYCLES)) u_commit_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (Commit_Btn),
    .pulse_o(commit_pulse)
  );

`ifdef AUTO_ADDR_INC_EN
  logic [ADDR_W-1:0] ptr_q;
  logic              ptr_valid_q;

  // The first commit after reset seeds the pointer from the switches; later ones ignore them.
  always_comb begin
    next_addr_d = ptr_valid_q ? ptr_q : Addr_SW;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      ptr_valid_q <= 1'b0;
    end else if (state_q == IDLE && commit_pulse) begin
      ptr_valid_q <= 1'b1;
    end else if (state_q == REQ && Mem_Ack) begin
      ptr_q <= mem_addr_q + 1'b1;
    end
  end
`else
  always_comb begin
    next_addr_d = Addr_SW;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      w_data_q   <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Commit has priority: a simultaneous load is dropped so the pre-load word is written.
          if (commit_pulse) begin
            state_q    <= REQ;
            mem_addr_q <= next_addr_d;
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
          end else if (load_pulse) begin
            w_data_q[{Select, 3'b000} +: 8] <= SW;
          end
        end
        REQ: begin
          if (Mem_Ack) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the lane select covers every case with a default, so no latch can form.
  always_comb begin
    LED = 8'h00;
    if (!busy_q) LED = w_data_q[{Select, 3'b000} +: 8];
  end

  assign W_Data   = w_data_q;
  assign Mem_Addr = mem_addr_q;
  assign Mem_Req  = mem_req_q;
  assign Busy     = busy_q;
endmodule

// File: tb/tb_switch_word_writer.sv
// Directed bench for switch_word_writer: lane loads, debounce latency, request handshake,
// dropped pulses and address sequencing (with or without AUTO_ADDR_INC_EN).
module tb_switch_word_writer;
  localparam int DB = 16;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    sw;
  logic [1:0]    sel;
  logic [AW-1:0] addr_sw;
  logic          load_btn, commit_btn, mem_ack;
  logic [31:0]   w_data;
  logic [AW-1:0] mem_addr;
  logic          mem_req, busy;
  logic [7:0]    led;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]   exp_w;
  logic [AW-1:0] m_ptr, m_last;
  bit            m_ptr_valid;

  switch_word_writer #(.DB_CYCLES(DB), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SW        (sw),
    .Select    (sel),
    .Addr_SW   (addr_sw),
    .Load_Btn  (load_btn),
    .Commit_Btn(commit_btn),
    .Mem_Ack   (mem_ack),
    .W_Data    (w_data),
    .Mem_Addr  (mem_addr),
    .Mem_Req   (mem_req),
    .Busy      (busy),
    .LED       (led)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
`ifdef AUTO_ADDR_INC_EN
    return m_ptr_valid ? m_ptr : a;
`else
    return a;
`endif
  endfunction

  // Press load for one lane, hold past the pulse, release and let the debouncer settle.
  task automatic load_lane(input logic [1:0] s, input logic [7:0] v);
    sel = s;
    sw = v;
    load_btn = 1'b1;
    tick(DB + 5);
    load_btn = 1'b0;
    tick(DB + 5);
    exp_w[8*s +: 8] = v;
  endtask

  // Raw press right after an edge: pulse after edge DB+3, Mem_Req visible after edge DB+4.
  task automatic do_commit(input logic [AW-1:0] a, input string tag);
    addr_sw = a;
    commit_btn = 1'b1;
    tick(DB + 3);
    check({tag, "_req_early"}, {31'd0, mem_req}, 32'd0);
    tick(1);
    m_last = exp_addr(a);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_addr"}, {26'd0, mem_addr}, {26'd0, m_last});
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_led_busy"}, {24'd0, led}, 32'd0);
    m_ptr_valid = 1'b1;
    commit_btn = 1'b0;
  endtask

  task automatic do_ack(input string tag);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    m_ptr = m_last + 1'b1;
    check({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    tick(1);
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    tick(DB + 5);
  endtask

  initial begin
    rst_n = 1'b0;
    sw = 8'h00;
    sel = 2'd0;
    addr_sw = '0;
    load_btn = 1'b0;
    commit_btn = 1'b0;
    mem_ack = 1'b0;
    exp_w = 32'h0;
    m_ptr = '0;
    m_last = '0;
    m_ptr_valid = 1'b0;
    tick(3);
    check("rst_wdata", w_data, 32'h0);
    check("rst_addr", {26'd0, mem_addr}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_led", {24'd0, led}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Assemble a word lane by lane and read each lane back on the LEDs.
    load_lane(2'd0, 8'h11);
    load_lane(2'd1, 8'h22);
    load_lane(2'd2, 8'h33);
    load_lane(2'd3, 8'h44);
    check("assemble_word", w_data, 32'h44332211);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check($sformatf("led_lane%0d", i), {24'd0, led}, 32'(8'h11 * (i + 1)));
    end

    // Bouncing press: exactly one load, DB+3 edges to the pulse, visible one edge later.
    sel = 2'd0;
    sw = 8'h5A;
    repeat (3) begin
      load_btn = 1'b1;
      tick(3);
      load_btn = 1'b0;
      tick(3);
    end
    check("bounce_no_load", w_data, exp_w);
    load_btn = 1'b1;
    tick(DB + 3);
    check("bounce_before_pulse", w_data, exp_w);
    tick(1);
    exp_w[7:0] = 8'h5A;
    check("bounce_latency", w_data, exp_w);
    sw = 8'hC3;
    tick(DB + 8);
    check("bounce_single_load", w_data, exp_w);
    load_btn = 1'b0;
    tick(DB + 8);
    check("release_no_load", w_data, exp_w);

    // Commit to address 5, ack sampled on the 4th edge of the request.
    do_commit(6'd5, "c5");
    tick(3);
    check("c5_req_held", {31'd0, mem_req}, 32'd1);
    check("c5_wdata_frozen", w_data, exp_w);
    do_ack("c5");
    sel = 2'd3;
    #1;
    check("led_after_done", {24'd0, led}, {24'd0, exp_w[31:24]});

    // Load during REQ is dropped; no timeout while ack is absent.
    do_commit(6'd9, "c9");
    sel = 2'd0;
    sw = 8'hAA;
    load_btn = 1'b1;
    tick(DB + 40);
    check("c9_no_timeout", {31'd0, mem_req}, 32'd1);
    do_ack("c9");
    check("load_in_req_dropped", w_data, exp_w);
    load_btn = 1'b0;
    tick(DB + 5);
    check("load_in_req_release", w_data, exp_w);

    // Load and commit pulses in the same cycle: commit wins with the old word.
    sel = 2'd1;
    sw = 8'h77;
    load_btn = 1'b1;
    do_commit(6'd3, "lc");
    check("lc_old_word", w_data, exp_w);
    load_btn = 1'b0;
    do_ack("lc");
    check("lc_lane_unchanged", w_data, exp_w);

    // Reset during REQ drops the request on the reset edge.
    do_commit(6'd12, "rq");
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_req", {31'd0, mem_req}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_wdata", w_data, 32'h0);
    rst_n = 1'b1;
    exp_w = 32'h0;
    m_ptr_valid = 1'b0;
    m_ptr = '0;
    tick(DB + 5);

    // Address sequence from 63: pointer wraps when enabled, else switches are followed.
    do_commit(6'd63, "a0");
    do_ack("a0");
    do_commit(6'd10, "a1");
    do_ack("a1");
    do_commit(6'd20, "a2");
    do_ack("a2");
`ifdef AUTO_ADDR_INC_EN
    check("auto_last_addr", {26'd0, mem_addr}, 32'd1);
`else
    check("manual_last_addr", {26'd0, mem_addr}, 32'd20);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
